// File: rtl/cpu_pkg.sv
// Shared CPU definitions: HI/LO operation encoding, default latencies and
// the arithmetic helpers used by the multiply/divide unit.
package cpu_pkg;

    // Encoding of the 3-bit op field driven by the decoder.
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    // 32x32 -> 64 product. Signed operands are sign-extended to 64 bits so a
    // single unsigned multiplier gives the right low 64 bits either way.
    function automatic hilo_t md_multiply(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        is_signed);
        logic [63:0] a_ext;
        logic [63:0] b_ext;
        logic [63:0] prod;
        a_ext = {{32{is_signed & a[31]}}, a};
        b_ext = {{32{is_signed & b[31]}}, b};
        prod  = a_ext * b_ext;
        return '{hi: prod[63:32], lo: prod[31:0]};
    endfunction

    // Quotient in lo, remainder in hi. Signed division works on magnitudes so
    // 0x80000000 / -1 wraps to 0x80000000 instead of overflowing. A zero
    // divisor returns zeros; the caller is expected to discard that result.
    function automatic hilo_t md_divide(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic        is_signed);
        logic        neg_q;
        logic        neg_r;
        logic [31:0] a_mag;
        logic [31:0] b_mag;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        neg_q = is_signed & (a[31] ^ b[31]);
        neg_r = is_signed & a[31];
        a_mag = (is_signed & a[31]) ? -a : a;
        b_mag = (is_signed & b[31]) ? -b : b;
        if (b_mag == 32'd0) begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        return '{hi: (neg_r ? -r_mag : r_mag), lo: (neg_q ? -q_mag : q_mag)};
    endfunction

endpackage

// File: rtl/md_counter.sv
// Loadable down-counter that stops at zero and flags it. Shared by the
// multiply/divide unit and intended for reuse as a timer.
module md_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    // Load takes priority; otherwise count down until zero and hold there.
    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_value;
        end else if (count_reg != '0) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Counter state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit. Computes the result at issue, holds it in
// pending registers for a fixed latency, then commits it to HI/LO.
module mult_div_unit
    import cpu_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        flush,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic             accept;
    logic             is_mul;
    logic             is_div;
    logic             load;
    logic [CNT_W-1:0] load_value;
    logic [CNT_W-1:0] count;
    logic             count_zero;
    logic             commit;
    logic             div_by_zero;
    hilo_t            mul_res;
    hilo_t            div_res;

    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;
    logic [31:0]      pend_hi_reg;
    logic [31:0]      pend_lo_reg;
    logic             pend_valid_reg;

    md_counter #(
        .W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .zero       (count_zero)
    );

    assign busy     = ~count_zero;
    assign md_stall = busy | (start & ~flush);
    // The final countdown edge (count 1 -> 0) is the commit edge.
    assign commit   = (count == CNT_W'(1));

    // Issue decode and result datapath; results are captured at the accept edge.
    always_comb begin
        accept      = start & ~flush & ~busy;
        is_mul      = (op == MD_MULT) || (op == MD_MULTU);
        is_div      = (op == MD_DIV)  || (op == MD_DIVU);
        load        = accept & (is_mul | is_div);
        load_value  = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        div_by_zero = (B == 32'd0);
        mul_res     = md_multiply(A, B, op == MD_MULT);
        div_res     = md_divide(A, B, op == MD_DIV);
    end

    // Pending result registers; a zero divisor leaves them untouched and
    // marks the operation as having nothing to commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_hi_reg    <= '0;
            pend_lo_reg    <= '0;
            pend_valid_reg <= 1'b0;
        end else if (load) begin
            if (is_mul) begin
                pend_hi_reg    <= mul_res.hi;
                pend_lo_reg    <= mul_res.lo;
                pend_valid_reg <= 1'b1;
            end else if (!div_by_zero) begin
                pend_hi_reg    <= div_res.hi;
                pend_lo_reg    <= div_res.lo;
                pend_valid_reg <= 1'b1;
            end else begin
                pend_valid_reg <= 1'b0;
            end
        end
    end

    // Architectural HI/LO: committed results or direct MTHI/MTLO writes.
    // An accept can only happen while idle, so the two never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (commit) begin
            if (pend_valid_reg) begin
                hi_reg <= pend_hi_reg;
                lo_reg <= pend_lo_reg;
            end
        end else if (accept) begin
            if (op == MD_MTHI) begin
                hi_reg <= A;
            end
            if (op == MD_MTLO) begin
                lo_reg <= A;
            end
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected busy length
// and HI/LO, a monitor pops and checks whenever busy falls.
module tb_mult_div_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        flush;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   mon_run_len = 0;
    logic mon_prev_busy = 1'b0;
    exp_t mon_e;

    mult_div_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .flush    (flush),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_op(input string name, input int cycles,
                             input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.cycles = cycles;
        e.hi     = h;
        e.lo     = l;
        e.name   = name;
        sb_q.push_back(e);
    endtask

    // Present one start for a cycle and confirm the combinational stall.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        #1;
        check("md_stall_issue", 64'(md_stall), 64'd1);
        step();
        start = 1'b0;
        op    = MD_NONE;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (busy === 1'b0) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: busy still %b after 64 cycles, required 0", name, busy);
        end
    endtask

    // Monitor: measure each busy run and check the committed HI/LO when it ends.
    initial begin
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                mon_run_len++;
            end else if (mon_prev_busy) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_completion: busy run %0d hi=%h lo=%h, required none",
                             mon_run_len, hi, lo);
                end else begin
                    mon_e = sb_q.pop_front();
                    $display("[TB] %s: busy=%0d hi=%h lo=%h", mon_e.name, mon_run_len, hi, lo);
                    check({mon_e.name, "_busy_len"}, 64'(mon_run_len), 64'(mon_e.cycles));
                    check({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
                    check({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
                end
                mon_run_len = 0;
            end
            mon_prev_busy = (busy === 1'b1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = MD_NONE;
        A     = '0;
        B     = '0;
        repeat (2) step();
        reset = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_md_stall", 64'(md_stall), 64'd0);

        // Multiply, signed and unsigned, issued back-to-back.
        expect_op("mult_neg", 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        issue(MD_MULT, 32'hFFFFFFFD, 32'd5);
        wait_idle("mult_neg");
        expect_op("multu", 5, 32'h00000004, 32'hFFFFFFF1);
        issue(MD_MULTU, 32'hFFFFFFFD, 32'd5);
        wait_idle("multu");
        expect_op("multu_max", 5, 32'hFFFFFFFE, 32'h00000001);
        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle("multu_max");

        // Divide: sign rules, unsigned, and the overflow corner.
        expect_op("div_neg", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle("div_neg");
        expect_op("divu", 10, 32'd1, 32'd3);
        issue(MD_DIVU, 32'd7, 32'd2);
        wait_idle("divu");
        expect_op("div_ovf", 10, 32'd0, 32'h80000000);
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle("div_ovf");

        // MTHI/MTLO visible the cycle after the accepting edge, no busy.
        issue(MD_MTHI, 32'h11, 32'd0);
        check("mthi_hi", 64'(hi), 64'h11);
        check("mthi_busy", 64'(busy), 64'd0);
        issue(MD_MTLO, 32'h22, 32'd0);
        check("mtlo_lo", 64'(lo), 64'h22);
        check("mtlo_hi_kept", 64'(hi), 64'h11);

        // Divide by zero: full busy period, HI/LO untouched.
        expect_op("div_zero", 10, 32'h11, 32'h22);
        issue(MD_DIV, 32'd5, 32'd0);
        wait_idle("div_zero");

        // Second start while busy is ignored; stall stays high.
        expect_op("mult_ignore", 5, 32'd0, 32'd42);
        issue(MD_MULT, 32'd6, 32'd7);
        step();
        start = 1'b1;
        op    = MD_MULT;
        A     = 32'd100;
        B     = 32'd100;
        for (int i = 0; i < 2; i++) begin
            check("stall_while_busy", 64'(md_stall), 64'd1);
            step();
        end
        start = 1'b0;
        op    = MD_NONE;
        wait_idle("mult_ignore");
        step();
        check("ignored_not_started", 64'(busy), 64'd0);

        // start with flush: nothing happens.
        start = 1'b1;
        flush = 1'b1;
        op    = MD_DIV;
        A     = 32'd9;
        B     = 32'd3;
        #1;
        check("flush_md_stall", 64'(md_stall), 64'd0);
        step();
        start = 1'b0;
        flush = 1'b0;
        op    = MD_NONE;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi", 64'(hi), 64'd0);
        check("flush_lo", 64'(lo), 64'd42);

        // flush during an in-flight multiply does not cancel it.
        expect_op("mult_flush_mid", 5, 32'd0, 32'd1);
        issue(MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
        flush = 1'b1;
        step();
        step();
        flush = 1'b0;
        wait_idle("mult_flush_mid");

        // Positive dividend, negative divisor.
        expect_op("div_negdiv", 10, 32'd1, 32'hFFFFFFFD);
        issue(MD_DIV, 32'd7, 32'hFFFFFFFE);
        wait_idle("div_negdiv");

        // Invalid op code is a no-op.
        start = 1'b1;
        op    = 3'd7;
        A     = 32'hDEAD;
        B     = 32'd1;
        step();
        start = 1'b0;
        op    = MD_NONE;
        check("invalid_busy", 64'(busy), 64'd0);
        check("invalid_hi", 64'(hi), 64'd1);
        check("invalid_lo", 64'(lo), 64'hFFFFFFFD);

        // Reset during the third busy cycle of a divide discards it.
        expect_op("div_reset", 3, 32'd0, 32'd0);
        issue(MD_DIVU, 32'd100, 32'd7);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_mid_busy", 64'(busy), 64'd0);
        check("reset_mid_hi", 64'(hi), 64'd0);
        check("reset_mid_lo", 64'(lo), 64'd0);
        repeat (15) step();
        check("no_late_commit_busy", 64'(busy), 64'd0);
        check("no_late_commit_hi", 64'(hi), 64'd0);
        check("no_late_commit_lo", 64'(lo), 64'd0);

        step();
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide responder for the E stage. Accepts one HI/LO operation per start pulse from the E-stage pipeline register outputs. Runs it over a fixed multi-cycle latency and commits the result to the architectural HI/LO registers. Raises a stall request that the hazard logic folds into the `lock` input of the pipeline registers.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; must be ≥1.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; must be ≥1.

Ports:
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: issue the operation in `op` this cycle; driven from decoded E-stage instruction.
- `op` input 3: operation code, encoded by the shared package: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `flush` input 1: the E-stage instruction is being cancelled (exception/eret in a later stage); suppresses `start`.
- `A` input 32: rs operand (forwarded E-stage R1).
- `B` input 32: rt operand (forwarded E-stage R2).
- `busy` output 1: an operation is in flight.
- `md_stall` output 1: `busy | (start & ~flush)`, combinational; hazard unit ORs it into `lock` for mfhi/mflo/HI-LO ops in D.
- `hi` output 32: architectural HI.
- `lo` output 32: architectural LO.

## Operation
- Accept condition at edge: `start & ~flush & ~busy & ~reset`. When `busy=1`, `start` is ignored; the hazard unit must hold the instruction.
- MULT: `{hi,lo}` ← signed 64-bit A×B. MULTU: unsigned 64-bit product.
- DIV: `lo` ← signed quotient, truncated toward zero; `hi` ← remainder, which takes the sign of the dividend.
  - A=0x80000000, B=0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (B=0, DIV or DIVU): the unit runs the full `DIV_CYCLES` busy period, then `hi` and `lo` remain unchanged.
- MTHI/MTLO: write A to `hi`/`lo` at the accepting edge. No busy period.
- For the multi-cycle ops, the result is computed from A/B at the accepting edge and stored in internal pending registers. The countdown register loads the latency.
- `busy` = (count ≠ 0). On every edge with count ≠ 0, count decrements. On the edge where it goes 1→0, `hi`/`lo` ← pending (the pending HI/LO words are left unchanged for divide-by-zero).
- `flush` has no effect on an operation already in flight. Once accepted, the operation always completes.
- Invalid `op` encodings with `start`: treated as no-op, no busy.

## Timing
- Reset: `busy=0`, count=0, `hi=0`, `lo=0`, pending cleared. Any in-flight operation is discarded with no commit.
- Accept at edge T, latency N: `busy=1` in the cycles after edges T..T+N-1, i.e. exactly N cycles. At edge T+N, `busy` falls and the new `hi`/`lo` appear in the same cycle.
- Back-to-back: a `start` in the first cycle with `busy=0` is accepted. The minimum issue interval is N+1 cycles for the same cycle accounting as above.
- MTHI/MTLO accepted at edge T: the value is visible in the cycle after T.
- `md_stall` rises combinationally in the issue cycle, so the following mfhi/mflo stalls from its first D cycle.
- Reset asserted together with `start`: reset wins.

## Structure
- Shared package (`cpu_pkg`): `op` encoding constants (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_NONE), and default latency constants.
- The decoder uses the same encoding constants to drive `op`.
- No sub-module required. The optional `md_counter` (a loadable down-counter with a zero flag) may be factored out for reuse by a later CP0 timer.

## Test plan
- MULT A=0xFFFFFFFD (−3), B=5 → `busy` high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU on the same operands → hi=0x00000004, lo=0xFFFFFFF1.
- DIV A=0xFFFFFFF9 (−7), B=2 → `busy` high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7, B=2 → lo=3, hi=1.
- Preload hi=0x11, lo=0x22 via MTHI/MTLO (each visible next cycle); then DIV with B=0 → `busy` 10 cycles, hi=0x11, lo=0x22 unchanged.
- MULT in flight, second `start` MULT at cycle 2 → ignored, `md_stall`=1 throughout. Only the first result commits, after 5 cycles.
- `start`+`flush` with DIV → no busy, `md_stall`=0, hi/lo unchanged. `flush` asserted mid-MULT → result still commits.
- `reset` asserted at busy cycle 3 of DIV → next cycle `busy=0`, hi=0, lo=0, with no late commit afterwards.
